master_port: RTL and testbench
==============================

# master_port

Bus-side serial initiator for the system bus: it accepts a parallel read or write request from a local master device and drives it serially onto a slave port. It serialises the address and write data LSB-first on `swdata`, then collects read data LSB-first from `srdata`. It is the initiator end of the `swdata`/`srdata`/`smode`/`mvalid`/`svalid`/`sready`/`ssplit` link that the `slave` block terminates.

## Interface
- `ADDR_WIDTH`, 12, address bits sent per transaction
- `DATA_WIDTH`, 8, data bits per write or read
- `TIMEOUT`, 256, max non-split cycles waiting for first/next read bit before error (≥2)

- `clk`  in  1  clock; all logic on rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `req`  in  1  local request; sampled only in IDLE
- `mode`  in  1  1 = write, 0 = read
- `addr`  in  ADDR_WIDTH  request address
- `wdata`  in  DATA_WIDTH  write data
- `rdata`  out  DATA_WIDTH  read data; valid with `ack` on reads, held until next read completes
- `ack`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle pulse with `ack` when a read timed out
- `busy`  out  1  high in every state except IDLE
- `swdata`  out  1  serial address/write data to slave
- `smode`  out  1  transaction mode to slave
- `mvalid`  out  1  transaction active
- `srdata`  in  1  serial read data from slave
- `svalid`  in  1  `srdata` bit valid this cycle
- `sready`  in  1  slave can accept a new transaction
- `ssplit`  in  1  slave has split the read; response is delayed

## Operation
- States: IDLE, ADDR, WDATA, RWAIT, DONE.
- IDLE: if `req && sready`, latch `mode`/`addr`/`wdata`, clear bit counter and timeout counter, go to ADDR. `req` with `sready`=0 waits; `req` is not latched until accepted, so it must be held by the requester.
- ADDR: `mvalid`=1, `smode`=latched mode, `swdata`=addr[bit], bit 0 first; one bit per cycle for ADDR_WIDTH cycles. After bit ADDR_WIDTH-1 go to WDATA (write) or RWAIT (read).
- WDATA: `mvalid`=1, `smode`=1, `swdata`=wdata[bit], bit 0 first, DATA_WIDTH cycles, then DONE.
- RWAIT: `mvalid`=1, `smode`=0, `swdata`=0. Each cycle with `svalid`=1 shifts `srdata` into bit position count (LSB first) and resets the timeout counter; gaps between valid bits are allowed. After DATA_WIDTH captured bits, update `rdata` and go to DONE.
- Timeout: the counter increments in RWAIT on cycles with `svalid`=0 and `ssplit`=0; `ssplit`=1 freezes it (no error while split). When it reaches TIMEOUT, go to DONE with error flagged; `rdata` is not updated.
- DONE: `mvalid`=0, `smode`=0, `swdata`=0, `ack`=1, `err`=timeout flag; next state IDLE unconditionally.
- `req` asserted outside IDLE is ignored. `svalid` outside RWAIT is ignored.
- The counter width is clog2 of max(ADDR_WIDTH, DATA_WIDTH, TIMEOUT)+1. No wrap occurs; the counter is cleared on each state entry.

## Timing
- Reset (async, any state): state=IDLE. `swdata`=0, `smode`=0, `mvalid`=0, `ack`=0, `err`=0, `busy`=0, `rdata`=0, all counters 0. Reset mid-transaction drops `mvalid` immediately with no `ack`.
- All outputs are registered.
- Accept edge T (IDLE, `req`&`sready`): the first address bit appears on `swdata` with `mvalid`=1 from T+1.
- Write: `mvalid` is high for exactly ADDR_WIDTH+DATA_WIDTH cycles. `ack` is high in the following cycle (latency ADDR_WIDTH+DATA_WIDTH+1 from the accept edge). The earliest next accept is the edge after `ack`.
- Read: `mvalid` is high from T+1 through the cycle in which the last `svalid` bit is sampled. `ack` and the new `rdata` appear in the following cycle.
- Back-to-back: IDLE lasts at least one cycle between transactions, so `mvalid` is low for at least 2 cycles (DONE + IDLE).

## Test plan
- Write, ADDR_WIDTH=12, DATA_WIDTH=8: `req`,`mode`=1, `addr`=0x4D5, `wdata`=0xD5, `sready`=1 -> `swdata` sequence 1,0,1,0,1,0,1,1,0,0,1,0 then 1,0,1,0,1,0,1,1. `smode`=1 and `mvalid`=1 for 20 cycles, then `ack` one cycle, `err`=0.
- Read: `mode`=0, `addr`=0x4D5. After the address bits, the slave drives `svalid` for 8 contiguous cycles with `srdata` 1,1,0,0,0,1,0,1 -> `rdata`=0xA3, `ack` one cycle after the last bit, `err`=0.
- Read with gaps and split: same as above but 3 idle cycles between bits 3 and 4, and `ssplit`=1 for 400 cycles before the first bit -> no timeout, `rdata`=0xA3, `err`=0.
- Timeout: read with `svalid`=`ssplit`=0 forever -> `ack`=`err`=1 exactly TIMEOUT+1 cycles after the last address bit. `rdata` keeps its previous value, then the block returns to IDLE.
- Back-pressure: `req`=1 with `sready`=0 for 10 cycles -> `mvalid` stays 0 and `busy`=0. Raising `sready` starts the transaction on the next edge.
- Reset mid-write: deassert `rstn` at address bit 5 -> `mvalid`/`smode`/`swdata`/`busy` go 0 immediately with no `ack`. After release, a new write completes normally.

Source files
------------

// File: rtl/master_port.sv
// master_port: serial initiator for the system bus.
// Shifts address/write data out LSB-first, gathers read data from the slave.
module master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ack,
    output logic                  err,
    output logic                  busy,
    output logic                  swdata,
    output logic                  smode,
    output logic                  mvalid,
    input  logic                  srdata,
    input  logic                  svalid,
    input  logic                  sready,
    input  logic                  ssplit
);

    localparam int M1   = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int MAXV = (M1 > TIMEOUT) ? M1 : TIMEOUT;
    localparam int CW   = $clog2(MAXV + 1);
    localparam int TW   = ADDR_WIDTH + DATA_WIDTH;

    localparam logic [CW-1:0] ALAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DLAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RWAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         tmo_q, tmo_d;
    logic                  mode_q, mode_d;
    logic [TW-1:0]         tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  terr_q, terr_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  swdata_q, swdata_d;
    logic                  smode_q, smode_d;
    logic                  mvalid_q, mvalid_d;

    // Next-state, bit counters, shift registers and timeout tracking.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        mode_d  = mode_q;
        tx_d    = tx_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        terr_d  = terr_q;
        unique case (state_q)
            S_IDLE: begin
                if (req && sready) begin
                    state_d = S_ADDR;
                    mode_d  = mode;
                    tx_d    = {wdata, addr};
                    cnt_d   = '0;
                    tmo_d   = '0;
                    terr_d  = 1'b0;
                end
            end
            S_ADDR: begin
                tx_d = {1'b0, tx_q[TW-1:1]};
                if (cnt_q == ALAST) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = mode_q ? S_WDATA : S_RWAIT;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_WDATA: begin
                tx_d = {1'b0, tx_q[TW-1:1]};
                if (cnt_q == DLAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_RWAIT: begin
                if (svalid) begin
                    rbuf_d = {srdata, rbuf_q[DATA_WIDTH-1:1]};
                    tmo_d  = '0;
                    if (cnt_q == DLAST) begin
                        rdata_d = rbuf_d;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end else if (!ssplit) begin
                    tmo_d = tmo_q + ONE;
                    if (tmo_d == TMAX) begin
                        tmo_d   = '0;
                        cnt_d   = '0;
                        terr_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every port comes straight off a flop.
    always_comb begin
        mvalid_d = state_d inside {S_ADDR, S_WDATA, S_RWAIT};
        busy_d   = (state_d != S_IDLE);
        ack_d    = (state_d == S_DONE);
        err_d    = (state_d == S_DONE) && terr_d;
        smode_d  = ((state_d == S_ADDR) && mode_d) || (state_d == S_WDATA);
        swdata_d = ((state_d == S_ADDR) || (state_d == S_WDATA)) && tx_d[0];
    end

    // State and output registers; reset drops the link immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tmo_q    <= '0;
            mode_q   <= 1'b0;
            tx_q     <= '0;
            rbuf_q   <= '0;
            rdata_q  <= '0;
            terr_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            swdata_q <= 1'b0;
            smode_q  <= 1'b0;
            mvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            mode_q   <= mode_d;
            tx_q     <= tx_d;
            rbuf_q   <= rbuf_d;
            rdata_q  <= rdata_d;
            terr_q   <= terr_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            swdata_q <= swdata_d;
            smode_q  <= smode_d;
            mvalid_q <= mvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign ack    = ack_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign swdata = swdata_q;
    assign smode  = smode_q;
    assign mvalid = mvalid_q;

endmodule

// File: tb/tb_master_port.sv
// tb_master_port: vector table, random transactions and corner sequences.
// The bench plays both the local requester and the serial slave.
module tb_master_port;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 256;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req;
    logic          mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          err;
    logic          busy;
    logic          swdata;
    logic          smode;
    logic          mvalid;
    logic          srdata;
    logic          svalid;
    logic          sready;
    logic          ssplit;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [DW-1:0] model_rdata;
    int            gap_q [DW];

    typedef struct {
        logic          m;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        int            split_len;
        int            gap_bit;
        int            gap_len;
        bit            no_resp;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    master_port #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .req   (req),
        .mode  (mode),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .err   (err),
        .busy  (busy),
        .swdata(swdata),
        .smode (smode),
        .mvalid(mvalid),
        .srdata(srdata),
        .svalid(svalid),
        .sready(sready),
        .ssplit(ssplit)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction, requester and slave side, checked cycle by cycle.
    task automatic run_txn(input logic m, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                           input int split_len, input bit no_resp,
                           input logic [DW-1:0] exp_rd, input logic exp_err,
                           input bit noisy);
        int cyc;
        req    = 1'b1;
        mode   = m;
        addr   = a;
        wdata  = wd;
        sready = 1'b1;
        tick();
        addr  = ~a;
        wdata = ~wd;
        mode  = ~m;
        for (int i = 0; i < AW; i++) begin
            chk("addr_mvalid", mvalid, 1);
            chk("addr_smode", smode, m);
            chk("addr_bit", swdata, (a >> i) & 1);
            chk("addr_busy", busy, 1);
            if (noisy) begin
                svalid = 1'($urandom_range(1, 0));
                srdata = 1'($urandom_range(1, 0));
            end
            tick();
        end
        req    = 1'b0;
        svalid = 1'b0;
        srdata = 1'b0;
        if (m) begin
            for (int i = 0; i < DW; i++) begin
                chk("wr_mvalid", mvalid, 1);
                chk("wr_smode", smode, 1);
                chk("wr_bit", swdata, (wd >> i) & 1);
                tick();
            end
        end else begin
            for (int s = 0; s < split_len; s++) begin
                ssplit = 1'b1;
                chk("split_mvalid", mvalid, 1);
                chk("split_ack", ack, 0);
                tick();
            end
            ssplit = 1'b0;
            if (no_resp) begin
                cyc = 1;
                while (!ack && cyc <= TO + 8) begin
                    chk("to_mvalid", mvalid, 1);
                    tick();
                    cyc++;
                end
                chk("to_latency", cyc, TO + 1);
            end else begin
                for (int j = 0; j < DW; j++) begin
                    for (int g = 0; g < gap_q[j]; g++) begin
                        svalid = 1'b0;
                        chk("gap_mvalid", mvalid, 1);
                        tick();
                    end
                    svalid = 1'b1;
                    srdata = rd[j];
                    chk("rd_mvalid", mvalid, 1);
                    chk("rd_smode", smode, 0);
                    chk("rd_swdata", swdata, 0);
                    tick();
                end
                svalid = 1'b0;
            end
        end
        chk("done_ack", ack, 1);
        chk("done_err", err, exp_err);
        chk("done_mvalid", mvalid, 0);
        chk("done_busy", busy, 1);
        if (!m && !exp_err) model_rdata = exp_rd;
        chk("done_rdata", rdata, model_rdata);
        tick();
        chk("idle_ack", ack, 0);
        chk("idle_err", err, 0);
        chk("idle_busy", busy, 0);
        chk("idle_mvalid", mvalid, 0);
    endtask

    initial begin
        int cyc;
        logic          rm;
        logic [AW-1:0] ra;
        logic [DW-1:0] rwd;
        logic [DW-1:0] rrd;

        rstn   = 1'b0;
        req    = 1'b0;
        mode   = 1'b0;
        addr   = '0;
        wdata  = '0;
        srdata = 1'b0;
        svalid = 1'b0;
        sready = 1'b0;
        ssplit = 1'b0;
        model_rdata = '0;

        vecs[0] = '{1'b1, 12'h4D5, 8'hD5, 8'h00, 0,   -1, 0,      1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 12'h4D5, 8'h00, 8'hA3, 0,   -1, 0,      1'b0, 8'hA3, 1'b0};
        vecs[2] = '{1'b0, 12'h4D5, 8'h00, 8'hA3, 400,  4, 3,      1'b0, 8'hA3, 1'b0};
        vecs[3] = '{1'b0, 12'h4D5, 8'h00, 8'h00, 0,   -1, 0,      1'b1, 8'hA3, 1'b1};
        vecs[4] = '{1'b1, 12'hFFF, 8'h00, 8'h00, 0,   -1, 0,      1'b0, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 12'h000, 8'hFF, 8'h5C, 0,    0, TO - 1, 1'b0, 8'h5C, 1'b0};
        vecs[6] = '{1'b0, 12'h800, 8'h00, 8'h81, 2,    7, TO - 1, 1'b0, 8'h81, 1'b0};

        #12;
        chk("rst_mvalid", mvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_swdata", swdata, 0);
        chk("rst_smode", smode, 0);
        chk("rst_rdata", rdata, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < DW; j++) gap_q[j] = 0;
            if (vecs[v].gap_bit >= 0) gap_q[vecs[v].gap_bit] = vecs[v].gap_len;
            run_txn(vecs[v].m, vecs[v].a, vecs[v].wd, vecs[v].rd,
                    vecs[v].split_len, vecs[v].no_resp,
                    vecs[v].exp_rd, vecs[v].exp_err, 1'b0);
        end

        for (int k = 0; k < 16; k++) begin
            rm  = 1'($urandom_range(1, 0));
            ra  = AW'($urandom);
            rwd = DW'($urandom);
            rrd = DW'($urandom);
            for (int j = 0; j < DW; j++) gap_q[j] = $urandom_range(2, 0);
            run_txn(rm, ra, rwd, rrd, $urandom_range(3, 0), 1'b0,
                    rrd, 1'b0, 1'b1);
        end

        req    = 1'b1;
        mode   = 1'b1;
        addr   = 12'h3A7;
        wdata  = 8'h5E;
        sready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_mvalid", mvalid, 0);
            chk("bp_busy", busy, 0);
        end
        sready = 1'b1;
        tick();
        req = 1'b0;
        chk("bp_start_mvalid", mvalid, 1);
        chk("bp_start_bit0", swdata, 1);
        cyc = 1;
        while (!ack && cyc <= AW + DW + 5) begin
            tick();
            cyc++;
        end
        chk("bp_ack_latency", cyc, AW + DW + 1);
        chk("bp_err", err, 0);
        tick();

        req   = 1'b1;
        mode  = 1'b1;
        addr  = 12'h4D5;
        wdata = 8'hD5;
        tick();
        req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_pre_smode", smode, 1);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_mvalid", mvalid, 0);
        chk("mid_rst_smode", smode, 0);
        chk("mid_rst_swdata", swdata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdata", rdata, 0);
        model_rdata = '0;
        tick();
        chk("mid_rst_ack", ack, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        for (int j = 0; j < DW; j++) gap_q[j] = 0;
        run_txn(1'b1, 12'h2C6, 8'h39, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
